// File: rtl/background_render_ctrl.sv
// background_render_ctrl: scaled background renderer with a 3-stage ROM/palette pipeline and frame-synchronous scene switching.
// Optional feature macro BG_FADE_EN: per-frame fade-out/fade-in around each scene switch.
module background_render_ctrl #(
  parameter int IMG_W   = 160,
  parameter int SCENE_W = 2
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               vde,
  input  logic               frame_start,
  input  logic               scene_req,
  input  logic [SCENE_W-1:0] scene_sel,
  output logic [SCENE_W+14:0] rom_addr,
  input  logic [4:0]         rom_q,
  output logic [4:0]         pal_index,
  input  logic [3:0]         pal_r,
  input  logic [3:0]         pal_g,
  input  logic [3:0]         pal_b,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               scene_ack,
  output logic               busy
);
  typedef enum logic [1:0] {
    ACTIVE,
    SWITCH
`ifdef BG_FADE_EN
    , FADE_OUT,
    FADE_IN
`endif
  } state_t;
  state_t state, state_n;
  logic [SCENE_W-1:0] scene, scene_n, tgt, tgt_n;
  logic pend, pend_n, ack_n;
  logic vde_d1, vde_d2;
  logic [14:0] offset;
`ifdef BG_FADE_EN
  logic [4:0] level, level_n;
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] l);
    return 4'(({5'b0, c} * {4'b0, l}) >> 4);
  endfunction
`endif
  // One ROM pixel covers a 4x4 block of screen pixels; 15 bits hold the full 160x120 offset.
  assign offset = 15'(DrawY >> 2) * 15'(IMG_W) + 15'(DrawX >> 2);
  assign pal_index = rom_q;
  assign busy = (state != ACTIVE);
  // Stage 1 registers the ROM address and starts the vde delay line that tracks the ROM/palette stages.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      vde_d1 <= 1'b0;
      vde_d2 <= 1'b0;
    end else begin
      rom_addr <= {scene, offset};
      vde_d1 <= vde;
      vde_d2 <= vde_d1;
    end
  end
  // Stage 3 registers the palette colour, blanked outside the visible region and scaled by the fade level.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vga_r <= 4'd0;
      vga_g <= 4'd0;
      vga_b <= 4'd0;
    end else begin
`ifdef BG_FADE_EN
      vga_r <= vde_d2 ? scale(pal_r, level) : 4'd0;
      vga_g <= vde_d2 ? scale(pal_g, level) : 4'd0;
      vga_b <= vde_d2 ? scale(pal_b, level) : 4'd0;
`else
      vga_r <= vde_d2 ? pal_r : 4'd0;
      vga_g <= vde_d2 ? pal_g : 4'd0;
      vga_b <= vde_d2 ? pal_b : 4'd0;
`endif
    end
  end
  // Scene-switch state register; reset abandons any transition in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ACTIVE;
      scene <= '0;
      tgt <= '0;
      pend <= 1'b0;
      scene_ack <= 1'b0;
`ifdef BG_FADE_EN
      level <= 5'd16;
`endif
    end else begin
      state <= state_n;
      scene <= scene_n;
      tgt <= tgt_n;
      pend <= pend_n;
      scene_ack <= ack_n;
`ifdef BG_FADE_EN
      level <= level_n;
`endif
    end
  end
  // Next-state logic: scene and level only move on frame_start; requests are ignored during the ack cycle.
  always_comb begin
    state_n = state;
    scene_n = scene;
    tgt_n = tgt;
    pend_n = pend;
    ack_n = 1'b0;
`ifdef BG_FADE_EN
    level_n = level;
`endif
    case (state)
      ACTIVE:
        if (pend) begin
          pend_n = !frame_start;
          ack_n = frame_start;
        end else if (scene_req && !scene_ack) begin
          pend_n = (scene_sel == scene);
          tgt_n = scene_sel;
`ifdef BG_FADE_EN
          state_n = (scene_sel == scene) ? ACTIVE : FADE_OUT;
`else
          state_n = (scene_sel == scene) ? ACTIVE : SWITCH;
`endif
        end
      SWITCH:
        if (frame_start) begin
          scene_n = tgt;
`ifdef BG_FADE_EN
          state_n = FADE_IN;
`else
          state_n = ACTIVE;
          ack_n = 1'b1;
`endif
        end
`ifdef BG_FADE_EN
      FADE_OUT:
        if (frame_start) begin
          level_n = level - 5'd1;
          state_n = (level == 5'd1) ? SWITCH : FADE_OUT;
        end
      FADE_IN:
        if (frame_start) begin
          level_n = level + 5'd1;
          state_n = (level == 5'd15) ? ACTIVE : FADE_IN;
          ack_n = (level == 5'd15);
        end
`endif
      default: state_n = ACTIVE;
    endcase
  end
endmodule

// File: tb/tb_background_render_ctrl.sv
// tb_background_render_ctrl: directed checks of pipeline latency, blanking and scene switching.
module tb_background_render_ctrl;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        vde = 1'b0;
  logic        frame_start = 1'b0;
  logic        scene_req = 1'b0;
  logic [1:0]  scene_sel = '0;
  logic [16:0] rom_addr;
  logic [4:0]  rom_q;
  logic [4:0]  pal_index;
  logic [3:0]  pal_r, pal_g, pal_b;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        scene_ack, busy;
  logic        pal_fixed = 1'b0;
  logic [11:0] pal_rgb = '0;
  int vectors = 0;
  int miscompares = 0;
  logic [9:0] xs [6] = '{10'd0, 10'd4, 10'd5, 10'd100, 10'd320, 10'd639};
  logic [9:0] ys [6] = '{10'd0, 10'd0, 10'd4, 10'd200, 10'd240, 10'd0};
  logic       vs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  background_render_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .vde(vde),
    .frame_start(frame_start), .scene_req(scene_req), .scene_sel(scene_sel),
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
    .pal_r(pal_r), .pal_g(pal_g), .pal_b(pal_b),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .scene_ack(scene_ack), .busy(busy)
  );

  always #5 Clk = ~Clk;
  // Synchronous ROM model with a simple address-derived pattern.
  always @(posedge Clk) rom_q <= rom_addr[4:0] ^ 5'h15;
  // Combinational palette model, overridable with a fixed colour.
  assign pal_r = pal_fixed ? pal_rgb[11:8] : pal_index[3:0];
  assign pal_g = pal_fixed ? pal_rgb[7:4] : {pal_index[4], pal_index[2:0]};
  assign pal_b = pal_fixed ? pal_rgb[3:0] : ~pal_index[3:0];

  function automatic logic [14:0] exp_addr(input logic [9:0] x, input logic [9:0] y);
    return 15'((32'(y) >> 2) * 160 + (32'(x) >> 2));
  endfunction

  function automatic logic [11:0] exp_rgb(input logic [14:0] a);
    logic [4:0] i;
    i = a[4:0] ^ 5'h15;
    return {i[3:0], i[4], i[2:0], ~i[3:0]};
  endfunction

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset_n = 1'b1;
    #2;
    Reset_n = 1'b0;
    #1;
    vectors++; if (rom_addr !== 17'd0) begin miscompares++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    vectors++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin miscompares++; $display("FAIL reset_vga: got %h want 000", {vga_r, vga_g, vga_b}); end
    vectors++; if (scene_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", scene_ack); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    repeat (2) step();
    Reset_n = 1'b1;
  endtask

  task automatic test_first_valid;
    pal_fixed = 1'b0;
    DrawX = 10'd639; DrawY = 10'd479; vde = 1'b1;
    step();
    vectors++; if (rom_addr !== 17'd19199) begin miscompares++; $display("FAIL corner_addr: got %0d want 19199", rom_addr); end
    vectors++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin miscompares++; $display("FAIL first_valid_early1: got %h want 000", {vga_r, vga_g, vga_b}); end
    step();
    vectors++; if (pal_index !== 5'h0A) begin miscompares++; $display("FAIL corner_pal_index: got %h want 0a", pal_index); end
    vectors++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin miscompares++; $display("FAIL first_valid_early2: got %h want 000", {vga_r, vga_g, vga_b}); end
    step();
    vectors++; if ({vga_r, vga_g, vga_b} !== 12'hA25) begin miscompares++; $display("FAIL corner_vga: got %h want a25", {vga_r, vga_g, vga_b}); end
  endtask

  task automatic test_blank;
    pal_fixed = 1'b1; pal_rgb = 12'hFDA;
    vde = 1'b0;
    repeat (3) step();
    vectors++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin miscompares++; $display("FAIL blank_vga: got %h want 000", {vga_r, vga_g, vga_b}); end
    vde = 1'b1;
    repeat (2) step();
    vectors++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin miscompares++; $display("FAIL blank_lead: got %h want 000", {vga_r, vga_g, vga_b}); end
    step();
    vectors++; if ({vga_r, vga_g, vga_b} !== 12'hFDA) begin miscompares++; $display("FAIL unblank_vga: got %h want fda", {vga_r, vga_g, vga_b}); end
    vde = 1'b0;
    repeat (2) step();
    vectors++; if ({vga_r, vga_g, vga_b} !== 12'hFDA) begin miscompares++; $display("FAIL blank_trail: got %h want fda", {vga_r, vga_g, vga_b}); end
    step();
    vectors++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin miscompares++; $display("FAIL blank_after: got %h want 000", {vga_r, vga_g, vga_b}); end
  endtask

  task automatic test_stream;
    logic [11:0] want;
    pal_fixed = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin DrawX = xs[c]; DrawY = ys[c]; vde = vs[c]; end
      step();
      if (c < 6) begin
        vectors++; if (rom_addr !== {2'b00, exp_addr(xs[c], ys[c])}) begin miscompares++; $display("FAIL stream_addr[%0d]: got %0d want %0d", c, rom_addr, exp_addr(xs[c], ys[c])); end
      end
      if (c >= 2) begin
        want = vs[c-2] ? exp_rgb(exp_addr(xs[c-2], ys[c-2])) : 12'h000;
        vectors++; if ({vga_r, vga_g, vga_b} !== want) begin miscompares++; $display("FAIL stream_vga[%0d]: got %h want %h", c - 2, {vga_r, vga_g, vga_b}, want); end
      end
    end
  endtask

  task automatic test_same_scene;
    pal_fixed = 1'b1; pal_rgb = 12'hFFF;
    DrawX = '0; DrawY = '0; vde = 1'b1;
    scene_req = 1'b1; scene_sel = 2'd0;
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL same_busy: got %b want 0", busy); end
    step();
    vectors++; if (scene_ack !== 1'b0) begin miscompares++; $display("FAIL same_ack_early: got %b want 0", scene_ack); end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    vectors++; if (scene_ack !== 1'b1) begin miscompares++; $display("FAIL same_ack: got %b want 1", scene_ack); end
    scene_req = 1'b0;
    vectors++; if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin miscompares++; $display("FAIL same_level: got %h want fff", {vga_r, vga_g, vga_b}); end
    step();
    vectors++; if (scene_ack !== 1'b0) begin miscompares++; $display("FAIL same_ack_pulse: got %b want 0", scene_ack); end
    vectors++; if (rom_addr[16:15] !== 2'd0) begin miscompares++; $display("FAIL same_scene: got %0d want 0", rom_addr[16:15]); end
  endtask

`ifdef BG_FADE_EN
  task automatic test_fade;
    int lvl;
    logic [3:0] want;
    scene_req = 1'b1; scene_sel = 2'd2;
    step();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fade_busy: got %b want 1", busy); end
    scene_sel = 2'd3;
    for (int k = 1; k <= 33; k++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      vectors++; if (scene_ack !== (k == 33)) begin miscompares++; $display("FAIL fade_ack[%0d]: got %b want %b", k, scene_ack, k == 33); end
      if (scene_ack) scene_req = 1'b0;
      repeat (3) step();
      lvl = (k <= 16) ? 16 - k : (k == 17) ? 0 : k - 17;
      want = 4'((15 * lvl) >> 4);
      vectors++; if ({vga_r, vga_g, vga_b} !== {want, want, want}) begin miscompares++; $display("FAIL fade_vga[%0d]: got %h want %h", k, {vga_r, vga_g, vga_b}, {want, want, want}); end
      if (k == 16) begin
        vectors++; if (rom_addr[16:15] !== 2'd0) begin miscompares++; $display("FAIL fade_scene_early: got %0d want 0", rom_addr[16:15]); end
      end
      if (k == 17) begin
        vectors++; if (rom_addr[16:15] !== 2'd2) begin miscompares++; $display("FAIL fade_scene: got %0d want 2", rom_addr[16:15]); end
      end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL fade_done_busy: got %b want 0", busy); end
  endtask
`else
  task automatic test_switch;
    int extra;
    scene_req = 1'b1; scene_sel = 2'd1;
    step();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL switch_busy: got %b want 1", busy); end
    scene_sel = 2'd3;
    step();
    vectors++; if (scene_ack !== 1'b0) begin miscompares++; $display("FAIL switch_ack_early: got %b want 0", scene_ack); end
    vectors++; if (rom_addr[16:15] !== 2'd0) begin miscompares++; $display("FAIL switch_scene_early: got %0d want 0", rom_addr[16:15]); end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    vectors++; if (scene_ack !== 1'b1) begin miscompares++; $display("FAIL switch_ack: got %b want 1", scene_ack); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL switch_idle: got %b want 0", busy); end
    scene_req = 1'b0;
    step();
    vectors++; if (rom_addr[16:15] !== 2'd1) begin miscompares++; $display("FAIL switch_scene: got %0d want 1", rom_addr[16:15]); end
    vectors++; if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin miscompares++; $display("FAIL switch_vga: got %h want fff", {vga_r, vga_g, vga_b}); end
    extra = 0;
    for (int k = 0; k < 2; k++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      if (scene_ack) extra++;
      step();
    end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL switch_extra_ack: got %0d want 0", extra); end
  endtask
`endif

  task automatic test_reset_mid;
    int acks;
    scene_req = 1'b1;
`ifdef BG_FADE_EN
    scene_sel = 2'd1;
    step();
    for (int k = 0; k < 8; k++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
    end
    repeat (2) step();
    vectors++; if ({vga_r, vga_g, vga_b} !== 12'h777) begin miscompares++; $display("FAIL mid_level8: got %h want 777", {vga_r, vga_g, vga_b}); end
`else
    scene_sel = 2'd2;
    step();
`endif
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    Reset_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
    vectors++; if (rom_addr !== 17'd0) begin miscompares++; $display("FAIL mid_rom_addr: got %0d want 0", rom_addr); end
    vectors++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin miscompares++; $display("FAIL mid_vga: got %h want 000", {vga_r, vga_g, vga_b}); end
    step();
    Reset_n = 1'b1;
    scene_req = 1'b0;
    acks = 0;
    for (int k = 0; k < 2; k++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      if (scene_ack) acks++;
      repeat (3) step();
    end
    vectors++; if (acks !== 0) begin miscompares++; $display("FAIL mid_no_ack: got %0d want 0", acks); end
    vectors++; if (rom_addr[16:15] !== 2'd0) begin miscompares++; $display("FAIL mid_scene: got %0d want 0", rom_addr[16:15]); end
    vectors++; if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin miscompares++; $display("FAIL mid_level16: got %h want fff", {vga_r, vga_g, vga_b}); end
  endtask

  initial begin
    test_reset();
    test_first_valid();
    test_blank();
    test_stream();
    test_same_scene();
`ifdef BG_FADE_EN
    test_fade();
`else
    test_switch();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/background_render_ctrl.md
BACKGROUND_RENDER_CTRL -- requirements
Module: background_render_ctrl

Interface
REQ-001 Parameter: IMG_W, 160, background image width in ROM pixels (one ROM pixel = 4x4 screen pixels).
REQ-002 Parameter: SCENE_W, 2, scene-select width; up to 4 backgrounds in one ROM.
REQ-003 Port: Clk  in  1  single system clock (pixel clock); all logic on rising edge.
REQ-004 Port: Reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: DrawX, DrawY  in  10 each  current screen pixel coordinates, 0..639 / 0..479.
REQ-006 Port: vde  in  1  high while (DrawX, DrawY) is in the visible region.
REQ-007 Port: frame_start  in  1  one-cycle pulse at the first cycle of vertical blanking.
REQ-008 Port: scene_req  in  1  level request for a scene change; held until scene_ack.
REQ-009 Port: scene_sel  in  SCENE_W  requested scene; stable while scene_req is high.
REQ-010 Port: rom_addr  out  SCENE_W+15  synchronous ROM address: {scene, (DrawY>>2)*IMG_W + (DrawX>>2)}.
REQ-011 Port: rom_q  in  5  ROM read data (palette index), valid 1 clock after rom_addr.
REQ-012 Port: pal_index  out  5  index to the combinational 32-entry palette; equals rom_q.
REQ-013 Port: pal_r, pal_g, pal_b  in  4 each  palette colour for pal_index, same cycle.
REQ-014 Port: vga_r, vga_g, vga_b  out  4 each  registered output colour.
REQ-015 Port: scene_ack  out  1  one-cycle pulse when the requested scene is fully displayed.
REQ-016 Port: busy  out  1  high in any state other than ACTIVE.

Function
REQ-017 Pipeline: stage 1 registers rom_addr and vde; stage 2 is the ROM read; stage 3 registers scaled palette colour; vga_* latency 3 clocks from DrawX/DrawY.
REQ-018 vga_* shall be 0 in any cycle where vde delayed by 3 clocks is low.
REQ-019 The address multiply shall use at least 15 bits; no truncation for DrawY>>2 = 119, DrawX>>2 = 159 (offset 19199).
REQ-020 States: ACTIVE, FADE_OUT, SWITCH, FADE_IN; FADE_* exist only with BG_FADE_EN.
REQ-021 ACTIVE: scene_req high and scene_sel != scene -> FADE_OUT (SWITCH without fade); scene_sel == scene -> scene_ack pulsed on the next frame_start, stay ACTIVE.
REQ-022 scene_req is sampled only in ACTIVE; changes to scene_sel while busy are ignored.
REQ-023 FADE_OUT: level decrements by 1 on each frame_start from 16; on reaching 0 -> SWITCH.
REQ-024 SWITCH: on next frame_start, scene <= scene_sel; -> FADE_IN (ACTIVE without fade, with scene_ack pulsed that cycle).
REQ-025 FADE_IN: level increments by 1 on each frame_start; on reaching 16 -> ACTIVE and scene_ack pulses in the same cycle.
REQ-026 scene and level shall change only on frame_start cycles (no mid-frame tearing).
REQ-027 Scaling: each channel out = (pal_c * level) >> 4, level 5-bit 0..16; level 16 passes colour unchanged, level 0 gives 0.
REQ-028 frame_start coincident with scene_req in ACTIVE: transition to FADE_OUT/SWITCH; level does not change in that cycle.

Reset
REQ-029 Reset_n low asynchronously forces: state ACTIVE, scene 0, level 16, rom_addr 0, vga_* 0, scene_ack 0, busy 0, pipeline vde 0.
REQ-030 Reset mid-fade or mid-switch abandons the transition; no scene_ack is issued; requester must re-assert.
REQ-031 First valid vga_* after reset release appears 3 clocks after the first cycle with vde high.

Configuration
REQ-032 Macro BG_FADE_EN defined: FADE_OUT/FADE_IN states, level counter and multipliers compiled in; scene change takes 16 + 1 + 16 frames.
REQ-033 BG_FADE_EN undefined: level fixed at 16, no multipliers, palette colour registered directly; scene change completes at the next frame_start after acceptance.

Verification
REQ-034 Reset, DrawX=639, DrawY=479, vde=1, scene 0 -> rom_addr = 19199 one clock later; vga_* = pal_* three clocks later.
REQ-035 vde=0 with pal_r/g/b = F/D/A -> vga_* = 0/0/0 after 3 clocks.
REQ-036 BG_FADE_EN, scene_req=1, scene_sel=2 -> busy next clock; pal=F/F/F gives vga=E/E/E after 1st frame_start (level 15); scene=2 after 17th frame_start; scene_ack after 33rd frame_start; rom_addr[16:15]=2.
REQ-037 No BG_FADE_EN, scene_req=1, scene_sel=1 -> scene=1 and one scene_ack at next frame_start; vga_* equals pal_* throughout.
REQ-038 scene_req with scene_sel == scene (0) -> no busy, scene_ack at next frame_start, level stays 16.
REQ-039 Reset_n pulsed low during FADE_OUT at level 8 -> immediately ACTIVE, scene 0, level 16, busy 0, no scene_ack.
